// File: rtl/alu_pwr_ctrl.sv
// alu_pwr_ctrl: power-sequencing and issue controller for the switchable ALU domain.
// Orders alu_pwr_en / iso_en so that power leads isolation release and isolation
// leads power removal, and turns requests into single-cycle alu_start pulses.
module alu_pwr_ctrl #(
  parameter int unsigned PWR_UP_CYCLES    = 4,
  parameter int unsigned ISO_SETUP_CYCLES = 2,
  parameter int unsigned IDLE_TIMEOUT     = 16,
  parameter int unsigned CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       force_off,
  input  logic       alu_busy,
  output logic       grant,
  output logic       alu_start,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic [1:0] pwr_state
);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_PWR_UP = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_PWR_DN = 2'd3;

  localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TIMEOUT);
  localparam logic             IDLE_EN  = (IDLE_TIMEOUT != 0);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant;
  logic             r_pwr_en;
  logic             r_iso;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_grant_nxt;
  logic             w_pwr_dn;

  // Grant and power-down decisions; a visible grant blocks both for one cycle
  // because the ALU's busy response to that grant is not yet observable.
  always_comb begin
    w_grant_nxt = (r_state == S_ACTIVE) && req && !alu_busy && !force_off && !r_grant;
    w_pwr_dn    = (r_state == S_ACTIVE) && !alu_busy && !r_grant && !w_grant_nxt &&
                  (force_off || (IDLE_EN && (r_cnt == IDLE_MAX)));
  end

  // Next state and shared dwell/idle counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_OFF: begin
        w_cnt_nxt = '0;
        if (req && !force_off) begin
          w_state_nxt = S_PWR_UP;
        end
      end
      S_PWR_UP: begin
        if (r_cnt == PU_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (w_pwr_dn) begin
          w_state_nxt = S_PWR_DN;
          w_cnt_nxt   = '0;
        end else if (req || alu_busy || r_grant) begin
          w_cnt_nxt = '0;
        end else if (r_cnt != IDLE_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PWR_DN: begin
        if (r_cnt == ISO_LAST) begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and outputs; outputs are registered from the next state so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_grant  <= 1'b0;
      r_pwr_en <= 1'b0;
      r_iso    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_pwr_en <= (w_state_nxt != S_OFF);
      r_iso    <= (w_state_nxt != S_ACTIVE);
    end
  end

  assign grant      = r_grant;
  assign alu_start  = r_grant;
  assign alu_pwr_en = r_pwr_en;
  assign iso_en     = r_iso;
  assign pwr_state  = r_state;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Self-checking bench for alu_pwr_ctrl: per-scenario tasks push expected output
// snapshots to a scoreboard queue as stimulus is driven and pop/compare them
// after each clock edge; ordering invariants are watched on every falling edge.
module tb_alu_pwr_ctrl;

  localparam int unsigned PU   = 4;
  localparam int unsigned ISO  = 2;
  localparam int unsigned IDLE = 16;

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_UP  = 2'd1;
  localparam logic [1:0] ST_ACT = 2'd2;
  localparam logic [1:0] ST_DN  = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic       pe;
    logic       iso;
    logic       gr;
    logic       start;
  } snap_t;

  typedef struct packed {
    logic       rq;
    logic       fo;
    logic       bz;
    logic [1:0] st;
    logic       gr;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, force_off, alu_busy;
  logic       grant, alu_start, alu_pwr_en, iso_en;
  logic [1:0] pwr_state;
  logic       req_b, force_off_b, alu_busy_b;
  logic       grant_b, alu_start_b, alu_pwr_en_b, iso_en_b;
  logic [1:0] pwr_state_b;

  int    n_run  = 0;
  int    n_fail = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  alu_pwr_ctrl #(
    .PWR_UP_CYCLES(PU), .ISO_SETUP_CYCLES(ISO), .IDLE_TIMEOUT(IDLE), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .force_off(force_off), .alu_busy(alu_busy),
    .grant(grant), .alu_start(alu_start), .alu_pwr_en(alu_pwr_en),
    .iso_en(iso_en), .pwr_state(pwr_state)
  );

  alu_pwr_ctrl #(
    .PWR_UP_CYCLES(PU), .ISO_SETUP_CYCLES(ISO), .IDLE_TIMEOUT(0), .CNT_W(8)
  ) dut_nt (
    .clk(clk), .rst(rst), .req(req_b), .force_off(force_off_b), .alu_busy(alu_busy_b),
    .grant(grant_b), .alu_start(alu_start_b), .alu_pwr_en(alu_pwr_en_b),
    .iso_en(iso_en_b), .pwr_state(pwr_state_b)
  );

  // Expected outputs for a state, from the per-state output table.
  function automatic snap_t mk(input logic [1:0] st, input logic gr);
    snap_t s;
    s.st    = st;
    s.pe    = (st != ST_OFF);
    s.iso   = (st != ST_ACT);
    s.gr    = gr;
    s.start = gr;
    return s;
  endfunction

  function automatic step_t stp(input logic rq, input logic fo, input logic bz,
                                input logic [1:0] st, input logic gr);
    return {rq, fo, bz, st, gr};
  endfunction

  function automatic snap_t snap_a();
    return {pwr_state, alu_pwr_en, iso_en, grant, alu_start};
  endfunction

  function automatic snap_t snap_b();
    return {pwr_state_b, alu_pwr_en_b, iso_en_b, grant_b, alu_start_b};
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d pe=%b iso=%b grant=%b start=%b", s.st, s.pe, s.iso, s.gr, s.start);
  endfunction

  task automatic monitor();
    logic pa, ia, pb, ib;
    pa = 1'b0; ia = 1'b1; pb = 1'b0; ib = 1'b1;
    forever begin
      @(negedge clk);
      n_run++;
      if (!alu_pwr_en && !iso_en) begin
        n_fail++;
        $display("FAIL inv_off_isolated: pe=%b iso=%b, required iso=1", alu_pwr_en, iso_en);
      end
      n_run++;
      if (!pa && alu_pwr_en && ia && !iso_en) begin
        n_fail++;
        $display("FAIL inv_pe_rise_iso_fall: iso fell with pe rise, required iso=1");
      end
      n_run++;
      if (alu_start && !(pwr_state == ST_ACT && !iso_en)) begin
        n_fail++;
        $display("FAIL inv_start_active: st=%0d iso=%b, required st=2 iso=0", pwr_state, iso_en);
      end
      n_run++;
      if ((!alu_pwr_en_b && !iso_en_b) || (!pb && alu_pwr_en_b && ib && !iso_en_b) ||
          (alu_start_b && !(pwr_state_b == ST_ACT && !iso_en_b))) begin
        n_fail++;
        $display("FAIL inv_nt: st=%0d pe=%b iso=%b start=%b, required ordering invariants",
                 pwr_state_b, alu_pwr_en_b, iso_en_b, alu_start_b);
      end
      pa = alu_pwr_en;   ia = iso_en;
      pb = alu_pwr_en_b; ib = iso_en_b;
    end
  endtask

  task automatic test_reset();
    step_t tbl[$];
    snap_t got, want;
    #1;
    exp_q.push_back(mk(ST_OFF, 1'b0));
    got = snap_a(); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_async: got %s, want %s", fmt(got), fmt(want));
    end
    req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(ST_OFF, 1'b0));
    got = snap_a(); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_held: got %s, want %s", fmt(got), fmt(want));
    end
    req = 1'b0;
    rst = 1'b0;
    for (int unsigned i = 0; i < 8; i++) tbl.push_back(stp(0, 0, 0, ST_OFF, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_idle step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_cold_wake();
    step_t tbl[$];
    snap_t got, want;
    for (int unsigned i = 0; i < PU; i++) tbl.push_back(stp(1, 0, 0, ST_UP, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 1));
    for (int unsigned i = 0; i < 3; i++) tbl.push_back(stp(0, 0, 0, ST_ACT, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL cold_wake step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t tbl[$];
    snap_t got, want;
    for (int unsigned i = 0; i < 8; i++) tbl.push_back(stp(1, 0, 0, ST_ACT, (i % 2) == 0));
    for (int unsigned i = 0; i < 6; i++) tbl.push_back(stp(1, 0, 1, ST_ACT, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 1));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_idle_timeout();
    step_t tbl[$];
    snap_t got, want;
    // One edge clears the count behind the visible grant, then IDLE increments,
    // then the saturated count triggers power-down.
    for (int unsigned i = 0; i < IDLE + 1; i++) tbl.push_back(stp(0, 0, 0, ST_ACT, 0));
    for (int unsigned i = 0; i < ISO; i++) tbl.push_back(stp(0, 0, 0, ST_DN, 0));
    for (int unsigned i = 0; i < 2; i++) tbl.push_back(stp(0, 0, 0, ST_OFF, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL idle_timeout step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_no_timeout();
    step_t tbl[$];
    snap_t got, want;
    for (int unsigned i = 0; i < PU; i++) tbl.push_back(stp(1, 0, 0, ST_UP, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 1));
    for (int unsigned i = 0; i < 40; i++) tbl.push_back(stp(0, 0, 0, ST_ACT, 0));
    foreach (tbl[k]) begin
      req_b = tbl[k].rq; force_off_b = tbl[k].fo; alu_busy_b = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_b(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL no_timeout step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_force_off();
    step_t tbl[$];
    snap_t got, want;
    for (int unsigned i = 0; i < PU; i++) tbl.push_back(stp(1, 0, 0, ST_UP, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 1));
    tbl.push_back(stp(0, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(1, 1, 0, ST_DN, 0));   // force_off beats req
    tbl.push_back(stp(1, 0, 0, ST_DN, 0));   // req during PWR_DN does not abort
    tbl.push_back(stp(1, 0, 0, ST_OFF, 0));
    tbl.push_back(stp(1, 0, 0, ST_UP, 0));   // single OFF cycle, then wake
    for (int unsigned i = 1; i < PU; i++) tbl.push_back(stp(1, 0, 0, ST_UP, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 1));
    for (int unsigned i = 0; i < 3; i++) tbl.push_back(stp(0, 1, 1, ST_ACT, 0));  // busy holds off
    for (int unsigned i = 0; i < ISO; i++) tbl.push_back(stp(0, 1, 0, ST_DN, 0));
    for (int unsigned i = 0; i < 5; i++) tbl.push_back(stp(1, 1, 0, ST_OFF, 0));  // req ignored
    tbl.push_back(stp(0, 0, 0, ST_OFF, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL force_off step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t tbl[$];
    snap_t got, want;
    for (int unsigned i = 0; i < 2; i++) tbl.push_back(stp(1, 0, 0, ST_UP, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid_up step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(mk(ST_OFF, 1'b0));
    got = snap_a(); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_in_pwr_up: got %s, want %s", fmt(got), fmt(want));
    end
    exp_q.push_back(mk(ST_OFF, 1'b0));
    got = snap_b(); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_nt_active: got %s, want %s", fmt(got), fmt(want));
    end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tbl.delete();
    for (int unsigned i = 0; i < PU; i++) tbl.push_back(stp(1, 0, 0, ST_UP, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(1, 0, 0, ST_ACT, 1));
    tbl.push_back(stp(0, 0, 0, ST_ACT, 0));
    tbl.push_back(stp(0, 1, 0, ST_DN, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid_dn step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(mk(ST_OFF, 1'b0));
    got = snap_a(); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_in_pwr_dn: got %s, want %s", fmt(got), fmt(want));
    end
    force_off = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tbl.delete();
    for (int unsigned i = 0; i < 3; i++) tbl.push_back(stp(0, 0, 0, ST_OFF, 0));
    foreach (tbl[k]) begin
      req = tbl[k].rq; force_off = tbl[k].fo; alu_busy = tbl[k].bz;
      exp_q.push_back(mk(tbl[k].st, tbl[k].gr));
      @(posedge clk);
      #1;
      got = snap_a(); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid_after step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    req         = 1'b0;
    force_off   = 1'b0;
    alu_busy    = 1'b0;
    req_b       = 1'b0;
    force_off_b = 1'b0;
    alu_busy_b  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_cold_wake();
    test_back_to_back();
    test_idle_timeout();
    test_no_timeout();
    test_force_off();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
